vga_text_writer: RTL

//  Character-cell screen buffer and cursor engine; the write side of the VGA text path.

---
 rtl/vga_text_writer_pkg.sv | 25 ++
 rtl/vga_text_writer_if.sv | 33 +++
 rtl/vga_text_ram.sv | 31 +++
 rtl/vga_text_writer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/vga_text_writer_pkg.sv
// +----------------------------------------------------------------------------+
// | vga_text_writer_pkg : shared control codes, FSM states, default grid size    |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

package vga_text_writer_pkg;

   localparam logic [7:0] CC_BS = 8'h08;
   localparam logic [7:0] CC_LF = 8'h0A;
   localparam logic [7:0] CC_FF = 8'h0C;
   localparam logic [7:0] CC_CR = 8'h0D;

   localparam int         DEF_COLS  = 80;
   localparam int         DEF_ROWS  = 30;
   localparam logic [7:0] DEF_BLANK = 8'h20;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/vga_text_writer_if.sv
// +----------------------------------------------------------------------------+
// | vga_text_writer_if : character stream, clear request, cursor and read port   |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

interface vga_text_writer_if #(
   parameter int COL_W = 7,
   parameter int ROW_W = 5
);
   logic             char_valid;
   logic             char_ready;
   logic [7:0]       char_in;
   logic             clr_req;
   logic             busy;
   logic [COL_W-1:0] cursor_col;
   logic [ROW_W-1:0] cursor_row;
   logic [COL_W-1:0] rd_col;
   logic [ROW_W-1:0] rd_row;
   logic [7:0]       rd_ascii;

   modport master (
      output char_valid, char_in, clr_req, rd_col, rd_row,
      input  char_ready, busy, cursor_col, cursor_row, rd_ascii
   );

   modport slave (
      input  char_valid, char_in, clr_req, rd_col, rd_row,
      output char_ready, busy, cursor_col, cursor_row, rd_ascii
   );
endinterface

`default_nettype wire

// File: rtl/vga_text_ram.sv
// +----------------------------------------------------------------------------+
// | vga_text_ram : simple dual-port cell RAM, sync write, read-first registered  |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_text_ram #(
   parameter int DEPTH  = 2400,
   parameter int ADDR_W = 12
) (
   input  wire logic              clk,
   input  wire logic              we,
   input  wire logic [ADDR_W-1:0] waddr,
   input  wire logic [7:0]        wdata,
   input  wire logic [ADDR_W-1:0] raddr,
   output      logic [7:0]        rdata
);

   logic [7:0] mem [DEPTH];

   // Read and write share one process so a same-cell collision returns old data.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

`default_nettype wire

// File: rtl/vga_text_writer.sv
// +----------------------------------------------------------------------------+
// | vga_text_writer : text screen buffer with cursor engine and clear sweep      |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_text_writer
   import vga_text_writer_pkg::*;
#(
   parameter int         COLS       = DEF_COLS,
   parameter int         ROWS       = DEF_ROWS,
   parameter logic [7:0] BLANK_CHAR = DEF_BLANK,
   parameter int         COL_W      = 7,
   parameter int         ROW_W      = 5
) (
   input wire logic          clk,
   input wire logic          rst,
   vga_text_writer_if.slave  bus
);

   localparam int CELLS  = COLS * ROWS;
   localparam int ADDR_W = $clog2(CELLS);

   state_t            r_state, w_state_d;
   logic [COL_W-1:0]  r_col, w_col_d;
   logic [ROW_W-1:0]  r_row, w_row_d, w_row_inc;
   logic [ADDR_W-1:0] r_clr_addr, w_clr_addr_d;
   logic [ADDR_W-1:0] w_cur_addr, w_rd_addr, w_raddr, w_waddr;
   logic [7:0]        w_wdata, w_ram_q;
   logic              w_we, w_rd_oob, r_rd_oob;

   assign bus.busy       = (r_state == ST_CLEAR);
   assign bus.char_ready = (r_state == ST_IDLE) && !bus.clr_req;
   assign bus.cursor_col = r_col;
   assign bus.cursor_row = r_row;

   assign w_cur_addr = ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(r_col);
   assign w_row_inc  = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + 1'b1;

   always_comb begin
      w_state_d    = r_state;
      w_col_d      = r_col;
      w_row_d      = r_row;
      w_clr_addr_d = r_clr_addr;
      w_we         = 1'b0;
      w_waddr      = w_cur_addr;
      w_wdata      = bus.char_in;
      if (r_state == ST_CLEAR) begin
         w_we    = 1'b1;
         w_waddr = r_clr_addr;
         w_wdata = BLANK_CHAR;
         if (r_clr_addr == ADDR_W'(CELLS - 1)) begin
            w_state_d    = ST_IDLE;
            w_col_d      = '0;
            w_row_d      = '0;
            w_clr_addr_d = '0;
         end else begin
            w_clr_addr_d = r_clr_addr + 1'b1;
         end
      end else if (bus.clr_req) begin
         w_state_d    = ST_CLEAR;
         w_clr_addr_d = '0;
      end else if (bus.char_valid) begin
         case (bus.char_in)
            CC_FF: begin
               w_state_d    = ST_CLEAR;
               w_clr_addr_d = '0;
            end
            CC_CR: w_col_d = '0;
            CC_LF: begin
               w_col_d = '0;
               w_row_d = w_row_inc;
            end
            CC_BS: begin
               if (r_col != '0) begin
                  w_col_d = r_col - 1'b1;
                  w_we    = 1'b1;
                  w_waddr = w_cur_addr - 1'b1;
                  w_wdata = BLANK_CHAR;
               end
            end
            default: begin
               w_we = 1'b1;
               if (r_col == COL_W'(COLS - 1)) begin
                  w_col_d = '0;
                  w_row_d = w_row_inc;
               end else begin
                  w_col_d = r_col + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_CLEAR;
         r_col      <= '0;
         r_row      <= '0;
         r_clr_addr <= '0;
         r_rd_oob   <= 1'b1;
      end else begin
         r_state    <= w_state_d;
         r_col      <= w_col_d;
         r_row      <= w_row_d;
         r_clr_addr <= w_clr_addr_d;
         r_rd_oob   <= w_rd_oob;
      end
   end

   // Out-of-range reads are parked on cell 0 and masked to blank after the RAM register.
   assign w_rd_oob  = ({1'b0, bus.rd_col} >= (COL_W + 1)'(COLS)) ||
                      ({1'b0, bus.rd_row} >= (ROW_W + 1)'(ROWS));
   assign w_rd_addr = ADDR_W'(bus.rd_row) * ADDR_W'(COLS) + ADDR_W'(bus.rd_col);
   assign w_raddr   = w_rd_oob ? '0 : w_rd_addr;
   assign bus.rd_ascii = r_rd_oob ? BLANK_CHAR : w_ram_q;

   vga_text_ram #(
      .DEPTH  (CELLS),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (w_we),
      .waddr (w_waddr),
      .wdata (w_wdata),
      .raddr (w_raddr),
      .rdata (w_ram_q)
   );

endmodule

`default_nettype wire
